// File: rtl/btb_pkg.sv
// btb_pkg: shared definitions for the branch target buffer controller.
//   - table entry field positions (48-bit entry)
//   - PC slice constants for index and tag
//   - 2-bit counter constants
//   - controller state enum and update-FIFO entry struct
package btb_pkg;

  localparam int ENT_W      = 48;
  localparam int VALID_BIT  = 47;
  localparam int CTR_MSB    = 46;
  localparam int CTR_LSB    = 45;
  localparam int TAG_MSB    = 44;
  localparam int TAG_LSB    = 30;
  localparam int TGT_MSB    = 29;
  localparam int TGT_LSB    = 0;

  localparam int IDX_MSB    = 7;
  localparam int IDX_LSB    = 2;
  localparam int PC_TAG_MSB = 22;
  localparam int PC_TAG_LSB = 8;

  localparam int IDX_W = IDX_MSB - IDX_LSB + 1;        // 6
  localparam int TAG_W = PC_TAG_MSB - PC_TAG_LSB + 1;  // 15
  localparam int TGT_W = TGT_MSB - TGT_LSB + 1;        // 30
  localparam int UPC_W = PC_TAG_MSB - IDX_LSB + 1;     // 21, pc[22:2]

  localparam logic [1:0] CTR_WEAK = 2'b10;
  localparam logic [1:0] CTR_MAX  = 2'd3;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // Buffered resolution update: pc[22:2], direction, target[31:2]
  typedef struct packed {
    logic [UPC_W-1:0] pc;
    logic             taken;
    logic [TGT_W-1:0] tgt;
  } upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO holding pending resolution updates.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        synchronous clear (drops all entries)
//   push, din  write side; ignored when full
//   pop, dout  read side; dout is the head (valid when !empty)
//   full, empty status
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  upd_t din,
  input  logic pop,
  output upd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  upd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/btb_ctrl.sv
// btb_ctrl: branch target buffer controller for the fetch stage.
// Drives a 64 x 48 distributed-RAM table: an async lookup port and a
// write port with async read-back used for read-modify-write.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              restart table clear, drop pending updates
//   busy               high while clearing
//   lk_pc / lk_*       combinational lookup (hit, taken, target)
//   upd_*              resolution update handshake (valid/ready)
//   tbl_raddr/rdata    lookup port of the table
//   tbl_waddr/wold/wdata/we  write + read-back port of the table
// Build option: define BTB_BYPASS_EN to forward a RUN-state write to a
// lookup of the same index in the same cycle.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             busy,
  input  logic [31:0]      lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [31:0]      lk_target,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  output logic [IDX_W-1:0] tbl_raddr,
  input  logic [ENT_W-1:0] tbl_rdata,
  output logic [IDX_W-1:0] tbl_waddr,
  input  logic [ENT_W-1:0] tbl_wold,
  output logic [ENT_W-1:0] tbl_wdata,
  output logic             tbl_we
);

  state_t           state;
  logic [IDX_W-1:0] sweep;
  logic             kill, run;
  upd_t             push_d, head;
  logic             full, empty, pop;

  // Sweep state machine: CLEAR walks every index once, then RUN.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_CLEAR;
      sweep <= '0;
    end else if (state == ST_CLEAR) begin
      sweep <= sweep + IDX_W'(1);
      if (sweep == '1) state <= ST_RUN;
    end
  end

  // rst/flush cycles neither accept nor retire updates
  assign kill      = rst | flush;
  assign run       = (state == ST_RUN);
  assign busy      = kill | (state == ST_CLEAR);
  assign upd_ready = run & ~kill & ~full;
  assign pop       = run & ~kill & ~empty;
  assign push_d    = '{pc: upd_pc[PC_TAG_MSB:IDX_LSB], taken: upd_taken,
                       tgt: upd_target[31:2]};

  btb_upd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (upd_valid & upd_ready),
    .din   (push_d),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Read-modify-write of the head entry against the current table word
  logic [IDX_W-1:0] h_idx;
  logic [TAG_W-1:0] h_tag;
  logic [1:0]       old_ctr, new_ctr;
  logic [TGT_W-1:0] new_tgt;
  logic             old_hit, rmw_we;
  logic [ENT_W-1:0] rmw_data;

  always_comb begin
    h_idx   = head.pc[IDX_W-1:0];
    h_tag   = head.pc[UPC_W-1:IDX_W];
    old_ctr = tbl_wold[CTR_MSB:CTR_LSB];
    old_hit = tbl_wold[VALID_BIT] & (tbl_wold[TAG_MSB:TAG_LSB] == h_tag);
    new_ctr = old_ctr;
    new_tgt = tbl_wold[TGT_MSB:TGT_LSB];
    rmw_we  = 1'b0;
    if (old_hit) begin
      rmw_we = 1'b1;
      if (head.taken) begin
        new_ctr = (old_ctr == CTR_MAX) ? old_ctr : old_ctr + 2'd1;
        new_tgt = head.tgt;
      end else begin
        new_ctr = (old_ctr == 2'd0) ? old_ctr : old_ctr - 2'd1;
      end
    end else if (head.taken) begin
      // not-taken misses are dropped; taken misses allocate weakly taken
      rmw_we  = 1'b1;
      new_ctr = CTR_WEAK;
      new_tgt = head.tgt;
    end
    rmw_data = {1'b1, new_ctr, h_tag, new_tgt};
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (!kill) begin
      if (state == ST_CLEAR) begin
        tbl_we    = 1'b1;
        tbl_waddr = sweep;
      end else if (!empty) begin
        tbl_waddr = h_idx;
        tbl_we    = rmw_we;
        if (rmw_we) tbl_wdata = rmw_data;
      end
    end
  end

  // Lookup
  logic [ENT_W-1:0] lk_ent;

  assign tbl_raddr = lk_pc[IDX_MSB:IDX_LSB];
`ifdef BTB_BYPASS_EN
  assign lk_ent = (tbl_we && run && (tbl_waddr == tbl_raddr)) ? tbl_wdata : tbl_rdata;
`else
  assign lk_ent = tbl_rdata;
`endif

  assign lk_hit    = ~rst & run & lk_ent[VALID_BIT] &
                     (lk_ent[TAG_MSB:TAG_LSB] == lk_pc[PC_TAG_MSB:PC_TAG_LSB]);
  assign lk_taken  = lk_hit & lk_ent[CTR_MSB];
  assign lk_target = lk_hit ? {lk_ent[TGT_MSB:TGT_LSB], 2'b00} : 32'd0;

  // PC bits outside index/tag and the counter LSB are not needed for lookup
  logic unused;
  assign unused = ^{lk_pc[31:23], lk_pc[1:0], upd_pc[31:23], upd_pc[1:0],
                    upd_target[1:0], lk_ent[CTR_LSB]};

endmodule
